pipeline_step_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipelined CPU with a single shared memory port. Each pipeline step is divided into an optional data access for the instruction in MEM, followed by an instruction fetch. The block arbitrates the one memory port between the MEM stage and IF, and waits on the memory ready handshake. It produces the PC, IF/ID and ID/EX write, bubble and flush controls, including load-use stalls and taken-branch flushes, and freezes the whole pipeline after HLT.

---
 rtl/pipeline_step_ctrl_pkg.sv | 16 +
 rtl/pipeline_step_ctrl_if.sv | 27 ++
 rtl/pipeline_step_ctrl_load_use.sv | 28 ++
 rtl/pipeline_step_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_step_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_step_ctrl_pkg.sv
// Shared definitions for the pipeline step controller.
// Holds the controller state encoding, the default register-id width and
// the statistics counter width. No ports.
package pipeline_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_D_WAIT = 2'd1,
    ST_I_WAIT = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int REG_ADDR_W_DEF = 2;
  localparam int STAT_W         = 16;

endpackage

// File: rtl/pipeline_step_ctrl_if.sv
// Shared memory port handshake between the step controller and memory.
// Signals:
//   mem_d_req   instruction in MEM needs a data access
//   mem_ready   memory completes the granted access this cycle
//   mem_grant_i port owned by instruction fetch
//   mem_grant_d port owned by the data access
// master: controller side, slave: memory / pipeline side.
interface pipeline_step_ctrl_if;
  logic mem_d_req;
  logic mem_ready;
  logic mem_grant_i;
  logic mem_grant_d;

  modport master (
    input  mem_d_req,
    input  mem_ready,
    output mem_grant_i,
    output mem_grant_d
  );

  modport slave (
    output mem_d_req,
    output mem_ready,
    input  mem_grant_i,
    input  mem_grant_d
  );
endinterface

// File: rtl/pipeline_step_ctrl_load_use.sv
// Load-use hazard detector: flags when the load in EX writes a register
// that the instruction in ID actually reads.
// Ports:
//   i_id_rs, i_id_rt          source register ids in ID
//   i_id_uses_rs, i_id_uses_rt ID instruction reads rs / rt
//   i_ex_mem_read             instruction in EX is a load
//   i_ex_rd                   destination id in EX
//   o_load_use                hazard present
module load_use_detect
  import pipeline_step_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  output logic                  o_load_use
);
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = i_id_uses_rs && (i_id_rs == i_ex_rd);
  assign w_rt_hit   = i_id_uses_rt && (i_id_rt == i_ex_rd);
  assign o_load_use = i_ex_mem_read && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/pipeline_step_ctrl.sv
// Sequencing controller for a 5-stage CPU sharing one memory port.
// Each step performs an optional data access for MEM, then an instruction
// fetch; the pipeline advances only on the cycle the fetch completes.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   bus (master)          memory handshake: d_req/ready in, grants out
//   id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd
//                         hazard inputs for load-use detection
//   ex_branch_taken       taken branch resolved in EX
//   halt_wb               HLT in WB
//   pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted
//                         pipeline controls
// Optional feature macro STALL_STATS_EN adds stat_steps, stat_load_use and
// stat_flush saturating 16-bit counters.
module pipeline_step_ctrl
  import pipeline_step_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_step_ctrl_if.master  bus,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  halt_wb,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_freeze,
  output logic                  halted
`ifdef STALL_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_steps,
  output logic [STAT_W-1:0]     stat_load_use,
  output logic [STAT_W-1:0]     stat_flush
`endif
);
  state_e r_state;
  state_e w_next;
  logic   w_grant_i;
  logic   w_grant_d;
  logic   w_advance;
  logic   w_halted;
  logic   w_load_use;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rs  (id_uses_rs),
    .i_id_uses_rt  (id_uses_rt),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd       (ex_rd),
    .o_load_use    (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next;
  end

  // Reset blocks every grant and advance in the same cycle, so an access in
  // flight is abandoned immediately rather than on the following edge.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_advance = 1'b0;
    w_halted  = 1'b0;
    if (!reset) begin
      unique case (r_state)
        ST_RUN: begin
          if (halt_wb) begin
            w_next = ST_HALTED;
          end else if (bus.mem_d_req) begin
            w_grant_d = 1'b1;
            w_next    = bus.mem_ready ? ST_I_WAIT : ST_D_WAIT;
          end else begin
            w_grant_i = 1'b1;
            if (bus.mem_ready) w_advance = 1'b1;
            else               w_next    = ST_I_WAIT;
          end
        end
        ST_D_WAIT: begin
          w_grant_d = 1'b1;
          if (bus.mem_ready) w_next = ST_I_WAIT;
        end
        ST_I_WAIT: begin
          w_grant_i = 1'b1;
          if (bus.mem_ready) begin
            w_advance = 1'b1;
            w_next    = ST_RUN;
          end
        end
        ST_HALTED: w_halted = 1'b1;
        default:   w_next   = ST_RUN;
      endcase
    end
  end

  assign bus.mem_grant_i = w_grant_i;
  assign bus.mem_grant_d = w_grant_d;
  assign halted          = w_halted;
  assign pipe_freeze     = !w_advance;
  // A taken branch overrides a load-use stall: the stalled ID instruction is
  // on the wrong path and is squashed anyway.
  assign pc_write        = w_advance && (ex_branch_taken || !w_load_use);
  assign if_id_write     = w_advance && !ex_branch_taken && !w_load_use;
  assign if_id_flush     = w_advance && ex_branch_taken;
  assign id_ex_bubble    = w_advance && (ex_branch_taken || w_load_use);

`ifdef STALL_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [STAT_W-1:0] r_stat_steps;
  logic [STAT_W-1:0] r_stat_load_use;
  logic [STAT_W-1:0] r_stat_flush;

  // No advance occurs in HALTED, so the counters freeze there naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_steps    <= '0;
      r_stat_load_use <= '0;
      r_stat_flush    <= '0;
    end else if (w_advance) begin
      r_stat_steps <= sat_inc(r_stat_steps);
      if (ex_branch_taken) r_stat_flush    <= sat_inc(r_stat_flush);
      else if (w_load_use) r_stat_load_use <= sat_inc(r_stat_load_use);
    end
  end

  assign stat_steps    = r_stat_steps;
  assign stat_load_use = r_stat_load_use;
  assign stat_flush    = r_stat_flush;
`endif
endmodule

// File: tb/tb_pipeline_step_ctrl.sv
module tb_pipeline_step_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0, halt_wb = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted;
`ifdef STALL_STATS_EN
  logic [15:0] stat_steps, stat_load_use, stat_flush;
`endif

  pipeline_step_ctrl_if bus ();

  always #5 clk = ~clk;

  pipeline_step_ctrl #(.REG_ADDR_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .halt_wb         (halt_wb),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pipe_freeze     (pipe_freeze),
    .halted          (halted)
`ifdef STALL_STATS_EN
    ,
    .stat_steps      (stat_steps),
    .stat_load_use   (stat_load_use),
    .stat_flush      (stat_flush)
`endif
  );

  // staged stimulus for the next cycle
  bit       s_rst, s_dreq, s_rdy, s_halt, s_br, s_emr, s_urs, s_urt;
  bit [1:0] s_erd, s_rs, s_rt;

  // Reference model: a step is a list of pending memory accesses
  // (1 = data, 2 = fetch). Grant goes to the head; completing the fetch
  // ends the step and advances the pipeline.
  int q[$];
  bit m_halted = 1'b0;
  int m_steps = 0, m_lu = 0, m_fl = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    s_rst = 0; s_dreq = 0; s_rdy = 0; s_halt = 0; s_br = 0; s_emr = 0;
    s_urs = 0; s_urt = 0; s_erd = 0; s_rs = 0; s_rt = 0;
  endtask

  task automatic tick(input string tag);
    bit gi, gd, adv, hl, lu, go_halt;
    logic [7:0] obs, exp;
    @(posedge clk);
    #1;
    reset = s_rst; bus.mem_d_req = s_dreq; bus.mem_ready = s_rdy;
    halt_wb = s_halt; ex_branch_taken = s_br; ex_mem_read = s_emr;
    ex_rd = s_erd; id_rs = s_rs; id_rt = s_rt;
    id_uses_rs = s_urs; id_uses_rt = s_urt;
    #1;
    gi = 0; gd = 0; adv = 0; hl = 0; go_halt = 0;
    if (!s_rst) begin
      if (m_halted) hl = 1;
      else begin
        if (q.size() == 0) begin
          if (s_halt) go_halt = 1;
          else begin
            if (s_dreq) q.push_back(1);
            q.push_back(2);
          end
        end
        if (q.size() != 0) begin
          gd = (q[0] == 1);
          gi = (q[0] == 2);
          if (s_rdy) begin
            adv = (q[0] == 2);
            void'(q.pop_front());
          end
        end
      end
    end
    lu  = s_emr && ((s_urs && s_rs == s_erd) || (s_urt && s_rt == s_erd));
    exp = {gi, gd, adv && (s_br || !lu), adv && !s_br && !lu, adv && s_br,
           adv && (s_br || lu), !adv, hl};
    obs = {bus.mem_grant_i, bus.mem_grant_d, pc_write, if_id_write, if_id_flush,
           id_ex_bubble, pipe_freeze, halted};
    check(tag, {24'd0, obs}, {24'd0, exp});
`ifdef STALL_STATS_EN
    check({tag, "_steps"}, {16'd0, stat_steps},    m_steps);
    check({tag, "_lu"},    {16'd0, stat_load_use}, m_lu);
    check({tag, "_fl"},    {16'd0, stat_flush},    m_fl);
`endif
    if (s_rst) begin
      q.delete(); m_halted = 0; m_steps = 0; m_lu = 0; m_fl = 0;
    end else begin
      if (go_halt) m_halted = 1;
      if (adv) begin
        if (m_steps < 65535) m_steps++;
        if (s_br) begin if (m_fl < 65535) m_fl++; end
        else if (lu) begin if (m_lu < 65535) m_lu++; end
      end
    end
  endtask

  initial begin
    bus.mem_d_req = 1'b0;
    bus.mem_ready = 1'b0;

    // reset: outputs forced even with requests and ready present
    clr(); s_rst = 1; s_dreq = 1; s_rdy = 1; tick("reset0");
    tick("reset1");
    check("reset_freeze", {31'd0, pipe_freeze}, 32'd1);

    // back-to-back single-cycle steps
    clr(); s_rdy = 1;
    for (int i = 0; i < 5; i++) tick("run_adv");
    check("run_pc_write", {31'd0, pc_write}, 32'd1);

    // data access with two wait cycles, then fetch
    clr(); s_dreq = 1; tick("dwait0");
    tick("dwait1");
    s_rdy = 1; tick("dwait_done");
    check("d_no_adv", {31'd0, pipe_freeze}, 32'd1);
    clr(); s_rdy = 1; tick("ifetch_adv");
    check("i_adv", {31'd0, pc_write}, 32'd1);

    // load-use stall, then a normal step
    clr(); s_rdy = 1; s_emr = 1; s_erd = 2; s_rs = 2; s_urs = 1; tick("load_use");
    check("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    check("lu_pc", {31'd0, pc_write}, 32'd0);
    clr(); s_rdy = 1; tick("after_lu");

    // branch wins over load-use
    clr(); s_rdy = 1; s_br = 1; s_emr = 1; s_erd = 1; s_rt = 1; s_urt = 1; tick("branch_lu");
    check("br_flush", {31'd0, if_id_flush}, 32'd1);

    // reset in D_WAIT abandons the access
    clr(); s_dreq = 1; tick("pre_rst_dwait");
    s_rst = 1; tick("rst_in_dwait");
    clr(); s_rdy = 1; tick("post_rst_fetch");
    check("post_rst_gi", {31'd0, bus.mem_grant_i}, 32'd1);

    // halt: absorbing despite requests
    clr(); s_halt = 1; s_dreq = 1; s_rdy = 1; tick("halt_enter");
    s_halt = 0;
    for (int i = 0; i < 10; i++) tick("halted");
    check("halted_flag", {31'd0, halted}, 32'd1);
    clr(); s_rst = 1; tick("halt_reset");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst  = ($urandom_range(0, 39) == 0);
      s_halt = ($urandom_range(0, 59) == 0);
      s_dreq = $urandom_range(0, 1);
      s_rdy  = ($urandom_range(0, 9) < 6);
      s_br   = ($urandom_range(0, 3) == 0);
      s_emr  = $urandom_range(0, 1);
      s_urs  = $urandom_range(0, 1);
      s_urt  = $urandom_range(0, 1);
      s_erd  = 2'($urandom_range(0, 3));
      s_rs   = 2'($urandom_range(0, 3));
      s_rt   = 2'($urandom_range(0, 3));
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
